// File: rtl/rx_prbs_word_checker.sv
// -----------------------------------------------------------------------------
// rx_prbs_word_checker
//
// Reads 128-bit words from the read side of the RX dual-clock FIFO and checks
// each one against a self-synchronising PRBS pattern. The pattern is PRBS7,
// PRBS15, PRBS23 or PRBS31. A lock state machine decides whether the incoming
// stream is aligned. While locked, it accumulates saturating bit and error
// counters for the CSR block.
//
// Ports
//   clk             FIFO read-side clock
//   reset           asynchronous, active-high reset
//   enable          run the checker; low stops reads and forces resync
//   clear           synchronous pulse: zero counters and overflow sticky
//   pattern_sel     0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31
//   fifo_q          FIFO read data (bit 0 = oldest serial bit), valid the
//                   cycle after fifo_rdreq (normal, non-show-ahead FIFO)
//   fifo_rdempty    FIFO empty
//   fifo_wrfull     FIFO full, write clock domain (asynchronous here)
//   fifo_rdreq      FIFO read request
//   locked          lock state
//   bit_count       bits checked while locked (saturating)
//   err_count       bit errors seen while locked (saturating)
//   overflow_sticky FIFO was seen full since the last clear
//
// Pipeline: a word requested in cycle t is captured at the edge ending t+1.
// It is predicted and compared at the edge ending t+2. It updates the
// FSM and counters at the edge ending t+3.
// -----------------------------------------------------------------------------
module rx_prbs_word_checker #(
    parameter int LOCK_WORDS   = 4,
    parameter int UNLOCK_WORDS = 4,
    parameter int CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [1:0]       pattern_sel,
    input  logic [127:0]     fifo_q,
    input  logic             fifo_rdempty,
    input  logic             fifo_wrfull,
    output logic             fifo_rdreq,
    output logic             locked,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count,
    output logic             overflow_sticky
);

    localparam int RUN_MAX = (LOCK_WORDS > UNLOCK_WORDS) ? LOCK_WORDS : UNLOCK_WORDS;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Predicted value of each bit of cur, from the two taps earlier in the
    // serial stream {cur, prv}. A slice starting at 128-A gives bit n the
    // value x[128+n-A].
    function automatic logic [127:0] predict(input logic [127:0] cur,
                                             input logic [127:0] prv,
                                             input logic [1:0]   sel);
        logic [255:0] x;
        logic [127:0] p;
        x = {cur, prv};
        case (sel)
            2'd0:    p = x[121 +: 128] ^ x[122 +: 128];  // taps 7,6
            2'd1:    p = x[113 +: 128] ^ x[114 +: 128];  // taps 15,14
            2'd2:    p = x[105 +: 128] ^ x[110 +: 128];  // taps 23,18
            2'd3:    p = x[97  +: 128] ^ x[100 +: 128];  // taps 31,28
            default: p = 128'd0;
        endcase
        return p;
    endfunction

    // Number of set bits in a word; the result is at most 128, so 8 bits suffice.
    function automatic logic [7:0] popcount128(input logic [127:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < 128; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    // Saturating add: the counters stick at all-ones and never wrap.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [1:0]       sel_r;
    logic             resync_s;
    logic             rd_pend_r;
    logic             v1_r;
    logic [127:0]     w1_r;
    logic [127:0]     prev_r;
    logic             prev_valid_r;
    logic             v2_r;
    logic [7:0]       errs_r;
    logic [7:0]       errs_s;
    state_t           state_r;
    state_t           state_n;
    logic [RUN_W-1:0] good_r;
    logic [RUN_W-1:0] good_n;
    logic [RUN_W-1:0] bad_r;
    logic [RUN_W-1:0] bad_n;
    logic             acc_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic             wrfull_meta_r;
    logic             wrfull_sync_r;
    logic             sticky_r;

    assign fifo_rdreq      = enable & ~fifo_rdempty;
    // Disabling the checker or changing the polynomial throws away all
    // history, because the old prediction taps are meaningless.
    assign resync_s        = ~enable | (pattern_sel != sel_r);
    assign locked          = (state_r == ST_LOCKED);
    assign bit_count       = bit_cnt_r;
    assign err_count       = err_cnt_r;
    assign overflow_sticky = sticky_r;

    // Register the polynomial select so a change can be detected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_r <= 2'd0;
        end else begin
            sel_r <= pattern_sel;
        end
    end

    // Error count for the word in stage 1. An all-zero word is never valid.
    always_comb begin
        errs_s = 8'd0;
        if (w1_r == 128'd0) begin
            errs_s = 8'd128;
        end else begin
            errs_s = popcount128(w1_r ^ predict(w1_r, prev_r, sel_r));
        end
    end

    // Read, capture and prediction pipeline. The first word after a resync
    // only seeds prev_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_r    <= 1'b0;
            v1_r         <= 1'b0;
            w1_r         <= 128'd0;
            prev_r       <= 128'd0;
            prev_valid_r <= 1'b0;
            v2_r         <= 1'b0;
            errs_r       <= 8'd0;
        end else if (resync_s) begin
            rd_pend_r    <= 1'b0;
            v1_r         <= 1'b0;
            prev_valid_r <= 1'b0;
            v2_r         <= 1'b0;
        end else begin
            rd_pend_r <= fifo_rdreq;
            v1_r      <= rd_pend_r;
            if (rd_pend_r) begin
                w1_r <= fifo_q;
            end
            v2_r <= v1_r & prev_valid_r;
            if (v1_r) begin
                prev_r       <= w1_r;
                prev_valid_r <= 1'b1;
                errs_r       <= errs_s;
            end
        end
    end

    // Lock FSM state and run-length registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_UNLOCKED;
            good_r  <= {RUN_W{1'b0}};
            bad_r   <= {RUN_W{1'b0}};
        end else begin
            state_r <= state_n;
            good_r  <= good_n;
            bad_r   <= bad_n;
        end
    end

    // Lock FSM next state. Run counters advance only on checked words, so
    // FIFO bubbles do not break a run.
    always_comb begin
        state_n = state_r;
        good_n  = good_r;
        bad_n   = bad_r;
        acc_s   = 1'b0;
        if (resync_s) begin
            state_n = ST_UNLOCKED;
            good_n  = {RUN_W{1'b0}};
            bad_n   = {RUN_W{1'b0}};
        end else if (v2_r) begin
            case (state_r)
                ST_UNLOCKED: begin
                    if (errs_r == 8'd0) begin
                        if ((good_r + RUN_W'(1)) == RUN_W'(LOCK_WORDS)) begin
                            state_n = ST_LOCKED;
                            good_n  = {RUN_W{1'b0}};
                            bad_n   = {RUN_W{1'b0}};
                        end else begin
                            good_n = good_r + RUN_W'(1);
                        end
                    end else begin
                        good_n = {RUN_W{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    // The word that causes an unlock is still counted.
                    acc_s = 1'b1;
                    if (errs_r != 8'd0) begin
                        if ((bad_r + RUN_W'(1)) == RUN_W'(UNLOCK_WORDS)) begin
                            state_n = ST_UNLOCKED;
                            good_n  = {RUN_W{1'b0}};
                            bad_n   = {RUN_W{1'b0}};
                        end else begin
                            bad_n = bad_r + RUN_W'(1);
                        end
                    end else begin
                        bad_n = {RUN_W{1'b0}};
                    end
                end
                default: begin
                    state_n = ST_UNLOCKED;
                    good_n  = {RUN_W{1'b0}};
                    bad_n   = {RUN_W{1'b0}};
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Bit and error accumulators. A clear takes priority over the word that
    // arrives in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (acc_s) begin
            bit_cnt_r <= sat_add(bit_cnt_r, CNT_W'(8'd128));
            err_cnt_r <= sat_add(err_cnt_r, CNT_W'(errs_r));
        end else begin
            bit_cnt_r <= bit_cnt_r;
            err_cnt_r <= err_cnt_r;
        end
    end

    // Two-flop synchroniser for the write-domain full flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrfull_meta_r <= 1'b0;
            wrfull_sync_r <= 1'b0;
        end else begin
            wrfull_meta_r <= fifo_wrfull;
            wrfull_sync_r <= wrfull_meta_r;
        end
    end

    // Overflow sticky: set by the synchronised full flag and cleared by clear,
    // which wins if both occur together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_r <= 1'b0;
        end else if (clear) begin
            sticky_r <= 1'b0;
        end else if (wrfull_sync_r) begin
            sticky_r <= 1'b1;
        end else begin
            sticky_r <= sticky_r;
        end
    end

endmodule

// File: tb/tb_rx_prbs_word_checker.sv
// -----------------------------------------------------------------------------
// Testbench for rx_prbs_word_checker.
//
// A queue-based FIFO model feeds words. Each word read is scored by a
// serial-stream reference model, and the result is pushed into a scoreboard
// with the edge at which the DUT must show it. A separate monitor at the
// falling edge applies due results to an abstract lock/counter model and
// compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_rx_prbs_word_checker;

    localparam int                CNT_W   = 16;
    localparam logic [63:0]       CNT_MAX = 64'd65535;
    localparam int                LOCKN   = 4;
    localparam int                UNLOCKN = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             clear;
    logic [1:0]       pattern_sel;
    logic [127:0]     fifo_q;
    logic             fifo_rdempty;
    logic             fifo_wrfull;
    logic             fifo_rdreq;
    logic             locked;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] err_count;
    logic             overflow_sticky;

    rx_prbs_word_checker #(
        .LOCK_WORDS  (LOCKN),
        .UNLOCK_WORDS(UNLOCKN),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (rst),
        .enable         (enable),
        .clear          (clear),
        .pattern_sel    (pattern_sel),
        .fifo_q         (fifo_q),
        .fifo_rdempty   (fifo_rdempty),
        .fifo_wrfull    (fifo_wrfull),
        .fifo_rdreq     (fifo_rdreq),
        .locked         (locked),
        .bit_count      (bit_count),
        .err_count      (err_count),
        .overflow_sticky(overflow_sticky)
    );

    typedef struct {
        int due;
        bit checked;
        int errs;
    } wres_t;

    int            checks = 0;
    int            errors = 0;
    int            edges  = 0;
    wres_t         wq[$];
    int            cq[$];
    int            rq[$];
    logic [127:0]  txq[$];
    int            ta[4]  = '{7, 15, 23, 31};
    int            tbp[4] = '{6, 14, 18, 28};

    logic [63:0]   gh;
    int            ga;
    int            gb;
    logic [127:0]  prev_rx;
    bit            have_prev;
    bit            rd_pending;
    bit            gap_mode;
    bit            gap_phase;
    int            clear_at;
    bit            clear_on_err;
    bit            mon_on;

    bit            m_locked;
    int            m_good;
    int            m_bad;
    logic [63:0]   m_bits;
    logic [63:0]   m_errs;
    wres_t         mr;

    always #5 clk = ~clk;

    // Edge counter that time-stamps scoreboard entries.
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Serial PRBS source: gh[k] holds the bit emitted k steps ago.
    task automatic gen_word(output logic [127:0] w);
        logic nb;
        w = 128'd0;
        for (int i = 0; i < 128; i++) begin
            nb   = gh[ga-1] ^ gh[gb-1];
            w[i] = nb;
            gh   = {gh[62:0], nb};
        end
    endtask

    // Count the received bits that break the recurrence s[g] = s[g-A] ^ s[g-B].
    function automatic int model_errs(input logic [127:0] w, input logic [127:0] p,
                                      input int a, input int b);
        logic [255:0] s;
        int n;
        if (w == 128'd0) return 128;
        s = {w, p};
        n = 0;
        for (int j = 128; j < 256; j++) begin
            if (s[j] != (s[j-a] ^ s[j-b])) n++;
        end
        return n;
    endfunction

    // Score a word that the DUT just read and queue its expected effect.
    task automatic model_word(input logic [127:0] w);
        wres_t r;
        r.due     = edges + 3;
        r.checked = have_prev;
        r.errs    = have_prev ? model_errs(w, prev_rx, ta[pattern_sel], tbp[pattern_sel]) : 0;
        prev_rx   = w;
        have_prev = 1'b1;
        if (clear_on_err && r.checked && r.errs != 0) begin
            clear_at     = edges + 3;
            clear_on_err = 1'b0;
        end
        wq.push_back(r);
    endtask

    // One clock: serve a pending read, drive inputs, then sample fifo_rdreq.
    task automatic step();
        logic [127:0] w;
        @(posedge clk);
        #1;
        if (rd_pending) begin
            if (txq.size() == 0) begin
                chk("fifo_underflow", 64'd1, 64'd0);
            end else begin
                w = txq.pop_front();
                fifo_q = w;
                model_word(w);
            end
        end
        gap_phase    = ~gap_phase;
        fifo_rdempty = (txq.size() == 0) || (gap_mode && gap_phase);
        clear        = (clear_at == edges + 1);
        if (clear) cq.push_back(edges + 1);
        #1;
        rd_pending = fifo_rdreq;
        chk("rdreq", 64'(fifo_rdreq), 64'(enable & ~fifo_rdempty));
    endtask

    task automatic drain();
        int lim;
        lim = 0;
        while ((txq.size() > 0 || wq.size() > 0 || rd_pending) && lim < 5000) begin
            step();
            lim++;
        end
        repeat (2) step();
        chk("drain_timeout", 64'(lim >= 5000), 64'd0);
    endtask

    task automatic pulse_clear();
        clear_at = edges + 2;
        repeat (3) step();
    endtask

    task automatic set_sel(input logic [1:0] s);
        pattern_sel = s;
        rq.push_back(edges + 1);
        have_prev = 1'b0;
        ga = ta[s];
        gb = tbp[s];
        gh = {$urandom, $urandom} | 64'd1;
    endtask

    task automatic push_clean(input int n);
        logic [127:0] w;
        for (int i = 0; i < n; i++) begin
            gen_word(w);
            txq.push_back(w);
        end
    endtask

    // Monitor: apply due scoreboard entries to the lock/counter model, then
    // compare the DUT against it.
    always @(negedge clk) begin
        if (mon_on) begin
            while (wq.size() > 0 && wq[0].due <= edges) begin
                mr = wq.pop_front();
                if (mr.checked) begin
                    if (m_locked) begin
                        m_bits = (m_bits + 64'd128 > CNT_MAX) ? CNT_MAX : m_bits + 64'd128;
                        m_errs = (m_errs + 64'(mr.errs) > CNT_MAX) ? CNT_MAX : m_errs + 64'(mr.errs);
                        if (mr.errs != 0) begin
                            m_bad++;
                            if (m_bad >= UNLOCKN) begin
                                m_locked = 1'b0;
                                m_good   = 0;
                            end
                        end else begin
                            m_bad = 0;
                        end
                    end else begin
                        if (mr.errs == 0) begin
                            m_good++;
                            if (m_good >= LOCKN) begin
                                m_locked = 1'b1;
                                m_bad    = 0;
                            end
                        end else begin
                            m_good = 0;
                        end
                    end
                end
            end
            while (rq.size() > 0 && rq[0] <= edges) begin
                void'(rq.pop_front());
                m_locked = 1'b0;
                m_good   = 0;
                m_bad    = 0;
            end
            while (cq.size() > 0 && cq[0] <= edges) begin
                void'(cq.pop_front());
                m_bits = 64'd0;
                m_errs = 64'd0;
            end
            chk("mon_locked", 64'(locked), 64'(m_locked));
            chk("mon_bit_count", 64'(bit_count), m_bits);
            chk("mon_err_count", 64'(err_count), m_errs);
        end
    end

    initial begin
        logic [127:0] w;
        logic [127:0] m97;
        int found;
        rst = 1'b1; enable = 1'b0; clear = 1'b0; pattern_sel = 2'd3;
        fifo_q = 128'd0; fifo_rdempty = 1'b1; fifo_wrfull = 1'b0;
        gap_mode = 1'b0; gap_phase = 1'b0; rd_pending = 1'b0;
        clear_at = -1; clear_on_err = 1'b0; have_prev = 1'b0; mon_on = 1'b0;
        m_locked = 1'b0; m_good = 0; m_bad = 0; m_bits = 64'd0; m_errs = 64'd0;
        ga = 31; gb = 28;
        gh = {$urandom, $urandom} | 64'd1;
        m97 = (128'd1 << 97) - 128'd1;

        repeat (3) step();
        chk("reset_locked", 64'(locked), 64'd0);
        chk("reset_bits", 64'(bit_count), 64'd0);
        chk("reset_errs", 64'(err_count), 64'd0);
        chk("reset_sticky", 64'(overflow_sticky), 64'd0);
        rst = 1'b0;
        mon_on = 1'b1;
        step();

        // Clean PRBS31: seed + 9 checked, lock after checked word 4.
        enable = 1'b1;
        push_clean(10);
        drain();
        chk("t1_bits", 64'(bit_count), 64'd640);
        chk("t1_errs", 64'(err_count), 64'd0);
        chk("t1_locked", 64'(locked), 64'd1);

        // Single flipped bit costs 3 errors.
        gen_word(w);
        txq.push_back(w ^ (128'd1 << 40));
        push_clean(2);
        drain();
        chk("t2_errs", 64'(err_count), 64'd3);
        chk("t2_bits", 64'(bit_count), 64'd1024);
        chk("t2_locked", 64'(locked), 64'd1);

        // Four all-zero words unlock; the last one is still counted.
        for (int i = 0; i < 4; i++) txq.push_back(128'd0);
        drain();
        chk("t3_errs", 64'(err_count), 64'd515);
        chk("t3_bits", 64'(bit_count), 64'd1536);
        chk("t3_unlocked", 64'(locked), 64'd0);
        push_clean(6);
        drain();
        chk("t3_relock", 64'(locked), 64'd1);

        // PRBS7 with the FIFO empty on alternate cycles.
        pulse_clear();
        set_sel(2'd0);
        repeat (2) step();
        gap_mode = 1'b1;
        push_clean(20);
        drain();
        gap_mode = 1'b0;
        chk("t4_bits", 64'(bit_count), 64'd1920);
        chk("t4_errs", 64'(err_count), 64'd0);
        chk("t4_locked", 64'(locked), 64'd1);

        // Saturation: three errored words in every four keeps lock.
        for (int i = 0; i < 2000; i++) begin
            gen_word(w);
            if ((i % 4) != 3) w = w ^ ({$urandom, $urandom, $urandom, $urandom} & m97);
            txq.push_back(w);
        end
        drain();
        chk("t5_bits_sat", 64'(bit_count), CNT_MAX);
        chk("t5_errs_sat", 64'(err_count), CNT_MAX);
        chk("t5_locked", 64'(locked), 64'd1);

        // Clear lands on the same edge as an errored word.
        clear_on_err = 1'b1;
        push_clean(1);
        gen_word(w);
        txq.push_back(w ^ (128'd1 << 10));
        drain();
        chk("t5_clear_bits", 64'(bit_count), 64'd0);
        chk("t5_clear_errs", 64'(err_count), 64'd0);
        chk("t5_clear_locked", 64'(locked), 64'd1);

        // One-cycle fifo_wrfull pulse sets the sticky flag.
        fifo_wrfull = 1'b1;
        step();
        fifo_wrfull = 1'b0;
        found = 0;
        for (int i = 0; i < 4 && found == 0; i++) begin
            step();
            if (overflow_sticky) found = 1;
        end
        chk("t6_sticky_set", 64'(found), 64'd1);
        repeat (5) step();
        chk("t6_sticky_hold", 64'(overflow_sticky), 64'd1);

        // A pattern change while locked drops lock on the next edge.
        set_sel(2'd3);
        step();
        chk("t6_sel_unlock", 64'(locked), 64'd0);
        chk("t6_sel_bits", 64'(bit_count), 64'd0);
        pulse_clear();
        chk("t6_sticky_clear", 64'(overflow_sticky), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_prbs_word_checker.md
Name: rx_prbs_word_checker

Overview:
- Consumes 128-bit words from the RX dual-clock FIFO read side, i.e. the converter's fifo_read data and rdempty status.
- Drives the FIFO read request and checks each word against a self-synchronising PRBS polynomial.
- Runs a lock state machine and accumulates bit and error counters for the CSR block.
- Sits in the data pattern checker, clocked by the FIFO read clock.

Parameters:
- LOCK_WORDS, 4: consecutive clean words required to enter LOCKED.
- UNLOCK_WORDS, 4: consecutive errored words required to leave LOCKED.
- CNT_W, 64: width of bit and error counters.

Ports:
- clk  in  1  FIFO read-side clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run checker; low stops reads.
- clear  in  1  synchronous counter/sticky clear pulse.
- pattern_sel  in  2  0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31.
- fifo_q  in  128  FIFO read data, bit 0 = oldest serial bit.
- fifo_rdempty  in  1  FIFO empty.
- fifo_wrfull  in  1  FIFO full, write domain (asynchronous here).
- fifo_rdreq  out  1  FIFO read request.
- locked  out  1  lock state.
- bit_count  out  CNT_W  bits checked while locked.
- err_count  out  CNT_W  bit errors while locked.
- overflow_sticky  out  1  FIFO was seen full.

Behaviour:
- Reset values: all outputs 0, FSM=UNLOCKED, prev_valid=0, all pipeline valids 0.
- FIFO read:
  - fifo_rdreq = enable & ~fifo_rdempty, combinational. The FIFO is normal (non-show-ahead) mode.
  - fifo_q is valid the cycle after rdreq. Stage 1 registers it as w1 with v1.
- Stage 2 (prediction):
  - If v1 & prev_valid: form the 256-bit vector {w1, prev}. For each bit n of w1 (global index 128+n), pred[n] = x[128+n-A] ^ x[128+n-B].
  - Taps (A,B): PRBS7 (7,6), PRBS15 (15,14), PRBS23 (23,18), PRBS31 (31,28).
  - errs = popcount(w1 ^ pred), 8 bits, range 0..128.
  - If w1 == 0, errs is forced to 128; an all-zeros stream is never valid.
  - prev <= w1 on every v1, and prev_valid <= 1.
  - The first word after prev_valid=0 seeds only: it is not checked and produces no stage-2 valid.
- Stage 3 (FSM and counters): acts on the stage-2 result (v2, errs).
  - Latency: a word read at cycle t updates counters/FSM at the clock edge ending cycle t+3.
  - UNLOCKED:
    - Clean word (errs==0): good_cnt++.
    - Errored word: good_cnt=0.
    - good_cnt reaching LOCK_WORDS: go to LOCKED, locked=1, bad_cnt=0.
    - Counters do not accumulate in UNLOCKED.
  - LOCKED:
    - Every checked word: bit_count += 128, err_count += errs. Both saturate at all-ones and never wrap.
    - Errored word: bad_cnt++. Clean word: bad_cnt=0.
    - bad_cnt reaching UNLOCK_WORDS: go to UNLOCKED, good_cnt=0. The word that triggers the unlock is still counted.
- Counter clear:
  - clear zeroes bit_count, err_count and overflow_sticky. It does not change FSM state.
  - clear in the same cycle as an accumulate: clear wins, and that word's contribution is dropped.
- Re-synchronisation:
  - enable low clears prev_valid and pipeline valids, and forces UNLOCKED.
  - A pattern_sel change (registered, compared each cycle) has the same effect.
  - Counters hold in both cases.
- Overflow: fifo_wrfull passes through a 2-flop synchroniser. A synchronised high sets overflow_sticky.
- Empty FIFO: no read, and bubbles propagate. The lock run counters only advance on checked words; gaps do not reset them.
- Reset mid-operation: returns to reset values immediately. It is asynchronous assert; deassertion is synchronised externally.

Test Plan:
- Reset, then enable=1, pattern_sel=3, feed a clean PRBS31 stream of 10 words. Required: first word is a seed only; locked rises after checked word 4 (word 5 read); bit_count=128×5=640 after word 10; err_count=0.
- In LOCKED, flip bit 40 of one word. Required: err_count += 3 (the bit itself plus its two tap predictions in the next word span); locked stays 1.
- In LOCKED, send 4 consecutive all-zero words. Required: err_count += 512, locked falls on the 4th zero word, bit_count += 512; a subsequent clean stream relocks after 4 clean checked words.
- Assert fifo_rdempty on alternating cycles during the PRBS7 stream. Required: fifo_rdreq is never high while empty; the count equals 128 × checked words; lock is still reached.
- Drive err_count and bit_count near all-ones, then pulse clear on the same cycle as an errored word. Required: both counters read 0; they saturate, not wrap, when preloaded to max-1.
- Pulse fifo_wrfull for 1 cycle. Required: overflow_sticky=1 within 3 cycles and holds until clear; a pattern_sel change mid-lock drops locked next cycle with counters unchanged.
